// File: rtl/csa_pkg.sv
// csa_pkg: shared sizing helpers for the carry-save tree adder.
package csa_pkg;

    localparam int MAX_OPS = 16;

    function automatic int rows_after(input int n, input int lvl);
        int r;
        r = n;
        for (int i = 0; i < lvl; i++) r = r - r / 3;
        return r;
    endfunction

    function automatic int num_levels(input int n);
        int r;
        int l;
        r = n;
        l = 0;
        while (r > 2) begin
            r = r - r / 3;
            l++;
        end
        return l;
    endfunction

    function automatic int out_width(input int w, input int n);
        return w + $clog2(n);
    endfunction

endpackage

// File: rtl/csa_row.sv
// csa_row: combinational 3:2 compressor; carry output is pre-shifted to its column weight.
module csa_row #(
    parameter int W = 4
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [W-1:0] c_i,
    output logic [W-1:0] sum_o,
    output logic [W-1:0] carry_o
);

    logic [W-1:0] maj;

    assign maj     = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
    assign sum_o   = a_i ^ b_i ^ c_i;
    assign carry_o = {maj[W-2:0], 1'b0};

endmodule

// File: rtl/csa_tree_adder.sv
// csa_tree_adder: pipelined multi-operand adder, one registered 3:2 level per stage plus a registered final add.
module csa_tree_adder
    import csa_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int NUM_OPS = 3,
    parameter bit SIGNED  = 1'b0,
    localparam int OW     = out_width(WIDTH, NUM_OPS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_OPS*WIDTH-1:0] in_ops,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OW-1:0]            out_sum
);

    localparam int LEVELS = num_levels(NUM_OPS);

    logic              adv;
    logic [OW-1:0]     row   [0:LEVELS][NUM_OPS];
    logic [OW-1:0]     lvl_d [1:LEVELS][NUM_OPS];
    logic [OW-1:0]     lvl_q [1:LEVELS][NUM_OPS];
    logic [LEVELS-1:0] vld_q;
    logic [LEVELS:0]   vld_d;
    logic [OW-1:0]     sum_d;
    logic [OW-1:0]     sum_q;
    logic              out_valid_q;

    // The whole pipe moves in lockstep, so a single stall term gates every stage.
    assign adv       = !out_valid_q || out_ready;
    assign in_ready  = adv;
    assign out_valid = out_valid_q;
    assign out_sum   = sum_q;
    assign vld_d     = {vld_q, in_valid};
    assign sum_d     = row[LEVELS][0] + row[LEVELS][1];

    for (genvar r = 0; r < NUM_OPS; r++) begin : g_ext
        assign row[0][r] = {{(OW-WIDTH){SIGNED & in_ops[r*WIDTH+WIDTH-1]}}, in_ops[r*WIDTH +: WIDTH]};
    end

    // Level l compresses groups of three rows into sum/carry pairs; leftovers shift down behind them.
    for (genvar l = 1; l <= LEVELS; l++) begin : g_lvl
        localparam int N = rows_after(NUM_OPS, l - 1);
        localparam int G = N / 3;
        for (genvar r = 0; r < NUM_OPS; r++) begin : g_row
            if (r < G) begin : g_csa
                csa_row #(.W(OW)) u_row (
                    .a_i     (row[l-1][3*r]),
                    .b_i     (row[l-1][3*r+1]),
                    .c_i     (row[l-1][3*r+2]),
                    .sum_o   (lvl_d[l][2*r]),
                    .carry_o (lvl_d[l][2*r+1])
                );
            end
            if (r < N - 3*G) begin : g_pass
                assign lvl_d[l][2*G+r] = row[l-1][3*G+r];
            end
            if (r >= N - G) begin : g_zero
                assign lvl_d[l][r] = '0;
            end
            assign row[l][r] = lvl_q[l][r];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i <= LEVELS; i++)
                for (int j = 0; j < NUM_OPS; j++)
                    lvl_q[i][j] <= '0;
            vld_q       <= '0;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
        end else if (adv) begin
            for (int i = 1; i <= LEVELS; i++)
                for (int j = 0; j < NUM_OPS; j++)
                    lvl_q[i][j] <= lvl_d[i][j];
            vld_q       <= vld_d[LEVELS-1:0];
            out_valid_q <= vld_d[LEVELS];
            sum_q       <= sum_d;
        end
    end

endmodule

// File: tb/tb_csa_tree_adder.sv
// tb_csa_tree_adder: directed vector table, backpressure/reset sequences and a randomised stream per operand count.
module tb_csa_tree_adder;

    typedef struct {
        int          sel;
        logic [63:0] ops;
        int          expv;
        int          lat;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic        div  [3];
    logic        dir  [3];
    logic        dov  [3];
    logic        dor  [3];
    logic [63:0] dops [3];
    logic [10:0] dsum [3];
    logic [5:0]  s0;
    logic [10:0] s1;
    logic [5:0]  s2;

    csa_tree_adder u_d0 (
        .clk(clk), .rst_n(rst_n), .in_valid(div[0]), .in_ready(dir[0]), .in_ops(dops[0][11:0]),
        .out_valid(dov[0]), .out_ready(dor[0]), .out_sum(s0));
    csa_tree_adder #(.WIDTH(8), .NUM_OPS(8)) u_d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(div[1]), .in_ready(dir[1]), .in_ops(dops[1]),
        .out_valid(dov[1]), .out_ready(dor[1]), .out_sum(s1));
    csa_tree_adder #(.SIGNED(1'b1)) u_d2 (
        .clk(clk), .rst_n(rst_n), .in_valid(div[2]), .in_ready(dir[2]), .in_ops(dops[2][11:0]),
        .out_valid(dov[2]), .out_ready(dor[2]), .out_sum(s2));

    assign dsum[0] = {5'b0, s0};
    assign dsum[1] = s1;
    assign dsum[2] = {5'b0, s2};

    logic        r_iv  [4];
    logic        r_ir  [4];
    logic        r_ov  [4];
    logic        r_or  [4];
    logic [79:0] r_ops [4];
    logic [8:0]  r_sum [4];
    logic [8:0]  em    [4][1024];

    function automatic int nops(input int g);
        return (g == 0) ? 3 : (g == 1) ? 4 : (g == 2) ? 7 : 16;
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_rnd
        localparam int N  = (g == 0) ? 3 : (g == 1) ? 4 : (g == 2) ? 7 : 16;
        localparam int OW = 5 + $clog2(N);
        logic [OW-1:0] s;
        csa_tree_adder #(.WIDTH(5), .NUM_OPS(N)) u_dut (
            .clk(clk), .rst_n(rst_n), .in_valid(r_iv[g]), .in_ready(r_ir[g]), .in_ops(r_ops[g][N*5-1:0]),
            .out_valid(r_ov[g]), .out_ready(r_or[g]), .out_sum(s));
        assign r_sum[g] = 9'(s);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        @(negedge clk);
        dops[v.sel] = v.ops;
        div[v.sel]  = 1'b1;
        dor[v.sel]  = 1'b1;
        @(posedge clk);
        n = 1;
        @(negedge clk);
        div[v.sel] = 1'b0;
        while (!dov[v.sel] && n < 20) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        chk($sformatf("vec_sum_d%0d", v.sel), 32'(dsum[v.sel]), v.expv);
        chk($sformatf("vec_latency_d%0d", v.sel), n, v.lat);
    endtask

    vec_t        vt [13];
    int          i, nxt, cyc, n, cnt, s;
    int          sent [4];
    int          got  [4];
    logic [10:0] held;

    initial begin
        vt = '{
            '{0, 64'hFFF, 45, 2}, '{0, 64'h000, 0, 2}, '{0, 64'h321, 6, 2}, '{0, 64'h10F, 16, 2},
            '{0, 64'hFA5, 30, 2},
            '{1, 64'hFFFF_FFFF_FFFF_FFFF, 2040, 5}, '{1, 64'h0, 0, 5},
            '{1, 64'h0807_0605_0403_0201, 36, 5}, '{1, 64'hFF00_0000_0000_0001, 256, 5},
            '{2, 64'h888, 40, 2}, '{2, 64'h8F7, 62, 2}, '{2, 64'h777, 21, 2}, '{2, 64'hFFF, 61, 2}
        };
        for (int k = 0; k < 3; k++) begin
            div[k] = 1'b0; dor[k] = 1'b1; dops[k] = '0;
        end
        for (int k = 0; k < 4; k++) begin
            r_iv[k] = 1'b0; r_or[k] = 1'b1; r_ops[k] = '0; sent[k] = 0; got[k] = 0;
        end
        held = '0;
        #1 rst_n = 1'b0;
        #1;
        chk("reset_out_valid", dov[0], 0);
        chk("reset_out_sum", dsum[0], 0);
        chk("reset_in_ready", dir[0], 1);
        chk("reset_out_valid_d1", dov[1], 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        foreach (vt[k]) run_vec(vt[k]);

        // Backpressure: stream 1..10 with a three-cycle consumer stall.
        i = 1; nxt = 1; cyc = 0;
        while (nxt <= 10 && cyc < 100) begin
            @(negedge clk);
            dor[0]  = !(cyc >= 4 && cyc < 7);
            div[0]  = (i <= 10);
            dops[0] = {52'b0, 4'(i), 4'(i), 4'(i)};
            #1;
            if (!dor[0]) begin
                chk("stall_in_ready", dir[0], 0);
                if (cyc == 4) held = dsum[0];
                else chk("stall_hold", dsum[0], held);
            end
            if (div[0] && dir[0]) i++;
            if (dov[0] && dor[0]) begin
                chk("bp_order", dsum[0], 3 * nxt);
                nxt++;
            end
            cyc++;
        end
        chk("bp_count", nxt, 11);
        div[0] = 1'b0; dor[0] = 1'b1;
        repeat (3) @(negedge clk);
        chk("bp_no_dup", dov[0], 0);

        // Asynchronous reset clears a held result mid-cycle.
        @(negedge clk);
        dops[0] = 64'h321; div[0] = 1'b1; dor[0] = 1'b0;
        @(negedge clk);
        div[0] = 1'b0;
        n = 0;
        while (!dov[0] && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("rstA_pre_valid", dov[0], 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rstA_out_valid", dov[0], 0);
        chk("rstA_out_sum", dsum[0], 0);
        chk("rstA_in_ready", dir[0], 1);
        @(negedge clk);
        rst_n = 1'b1; dor[0] = 1'b1;

        // In-flight results are discarded by reset on the deep pipe.
        run_vec(vt[5]);
        @(negedge clk);
        dops[1] = 64'h0101_0101_0101_0101; div[1] = 1'b1;
        @(negedge clk);
        dops[1] = 64'h0202_0202_0202_0202;
        @(negedge clk);
        div[1] = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rstB_out_valid", dov[1], 0);
        chk("rstB_out_sum", dsum[1], 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        dops[1] = 64'h0003_0201; div[1] = 1'b1;
        @(negedge clk);
        div[1] = 1'b0;
        cnt = 0;
        repeat (12) begin
            if (dov[1]) begin
                cnt++;
                if (cnt == 1) chk("rstB_first", dsum[1], 6);
            end
            @(negedge clk);
        end
        chk("rstB_count", cnt, 1);

        // Random streams for every operand count at once.
        cyc = 0;
        while ((got[0] < 1000 || got[1] < 1000 || got[2] < 1000 || got[3] < 1000) && cyc < 20000) begin
            @(negedge clk);
            for (int g = 0; g < 4; g++) begin
                r_iv[g]  = (sent[g] < 1000) && ($urandom_range(0, 3) != 0);
                r_or[g]  = ($urandom_range(0, 3) != 0);
                r_ops[g] = 80'({$urandom(), $urandom(), $urandom()});
            end
            #1;
            for (int g = 0; g < 4; g++) begin
                if (r_iv[g] && r_ir[g]) begin
                    s = 0;
                    for (int k = 0; k < nops(g); k++) s += int'(r_ops[g][k*5 +: 5]);
                    em[g][sent[g]] = 9'(s);
                    sent[g]++;
                end
                if (r_ov[g] && r_or[g]) begin
                    chk($sformatf("rnd_sum_n%0d", nops(g)), 32'(r_sum[g]), 32'(em[g][got[g] % 1024]));
                    got[g]++;
                end
            end
            cyc++;
        end
        for (int g = 0; g < 4; g++) chk($sformatf("rnd_count_n%0d", nops(g)), got[g], 1000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/csa_tree_adder.md
# csa_tree_adder

Parametrised, pipelined multi-operand adder. Sums NUM_OPS operands of WIDTH bits each through a Wallace-style tree of 3:2 carry-save compressor levels, followed by a final carry-propagate add. Each level is registered, and a valid/ready handshake supports backpressure. It generalises the team's fixed three-operand, 4-bit combinational adder into a reusable arithmetic block for accumulation and dot-product datapaths.

## Interface
Parameters:
- WIDTH, 4, bits per operand (≥1).
- NUM_OPS, 3, operand count (3..16).
- SIGNED, 0, 1 = operands are two's complement and sign-extended; 0 = zero-extended.
- OW (derived, not overridable): WIDTH + clog2(NUM_OPS). Output width.

Ports:
- clk, input, 1, sole clock. All state updates on the rising edge.
- rst_n, input, 1, reset. Asynchronous assert, active-low.
- in_valid, input, 1, operand set present.
- in_ready, output, 1, block accepts the operand set this cycle.
- in_ops, input, NUM_OPS*WIDTH, packed operands. Operand i sits at bits [i*WIDTH +: WIDTH].
- out_valid, output, 1, out_sum holds a result.
- out_ready, input, 1, consumer takes the result this cycle.
- out_sum, output, OW, sum of all operands.

## Operation
- LEVELS = number of 3:2 levels that reduce NUM_OPS rows to 2, computed as n → n − floor(n/3).
  - NUM_OPS=3 → 1 level; 4 → 2; 8 → 4; 16 → 6.
- Stage 0 (input): extend each operand to OW bits. Use sign extension if SIGNED=1, otherwise zero extension.
- Stages 1..LEVELS: each level groups its rows in threes, with the lowest index first.
  - Each group produces sum = a^b^c and carry = maj(a,b,c) << 1, truncated to OW bits.
  - Leftover rows (1 or 2) pass through unchanged.
  - The result of each level is registered.
- Final stage: carry-propagate add of the last two rows, mod 2^OW, registered into out_sum.
- Result equals the exact arithmetic sum. OW is wide enough that no overflow is possible in either mode.
- Each pipeline register carries a valid bit.
- Global advance: adv = !out_valid || out_ready.
  - in_ready = adv. This is a combinational path from out_ready; it is intended.
  - When adv=1, every stage loads from its predecessor. Bubbles (valid=0) propagate like data.
  - When adv=0, every stage holds. out_sum and out_valid remain stable.
- A transfer occurs on in_valid && in_ready (input side) and on out_valid && out_ready (output side).
- No state machine beyond the valid shift chain.

## Timing
- Reset values: out_valid=0, out_sum=0, all internal data and valid registers 0. in_ready=1 while in reset and immediately after.
- Latency L = LEVELS + 1 cycles.
  - Input accepted at edge k → out_valid=1 with its result after edge k+L, given no stall.
  - Default parameters: L = 2.
- Throughput: one result per cycle while out_ready=1.
- Simultaneous accept and output handshake in the same cycle is legal. The pipeline advances one slot.
- Stall (out_valid=1, out_ready=0): in_ready=0 in the same cycle, and no input is consumed.
- in_valid=0 while adv=1 inserts a bubble.
- Reset asserted mid-operation: all in-flight results are discarded and outputs return to their reset values asynchronously. The first result after reset release corresponds to the first input accepted after release.

## Structure
- Shared package csa_pkg holds:
  - function num_levels(n), returning the level count;
  - function out_width(w, n);
  - localparam MAX_OPS = 16.
- Sub-module csa_row: a combinational OW-bit 3:2 compressor with inputs a, b, c and outputs sum, carry (carry already shifted). It is instantiated per group, per level, with a generate loop.
- The top level contains the extension logic, the generate-built level registers, the final adder, and the valid chain.

## Test plan
- Default params: in_ops = {15,15,15}, out_ready=1 → out_sum=45 (6'b101101), out_valid exactly 2 cycles after accept.
- WIDTH=8, NUM_OPS=8, all operands 255 → OW=11, out_sum=2040, latency 5. All zeros → 0.
- SIGNED=1, WIDTH=4, NUM_OPS=3: operands {-8,-8,-8} → out_sum = 6'b101000 (−24). Operands {7,−1,−8} → 6'b111110 (−2).
- Backpressure, default params: stream the values 1..10 (each operand = i), holding out_ready=0 for 3 cycles mid-stream. Required response:
  - in_ready=0 throughout the stall;
  - out_sum held stable;
  - outputs 3,6,...,30 in order, with no loss or duplication.
- Reset mid-flight: accept 2 inputs, assert rst_n=0 before either emerges → out_valid=0 and out_sum=0 immediately. After release, a new input {1,2,3} → 6 is the first and only output.
- Random stream: 1000 transactions for each of NUM_OPS ∈ {3,4,7,16}, with random in_valid/out_ready → every result matches the reference model sum, in order.
